// File: rtl/esc_mode_tx.sv
`default_nettype none
// ============================================================================
//  Module      : esc_mode_tx
//  Description : Master-side C-PHY low-power escape-mode transmitter.
//                Drives LP line states on A/B/C through the sequence
//                STOP -> ENTRY -> CMD -> (LPDT_IDLE/DATA | ULPS_HOLD) -> EXIT
//                -> STOP.
//                Command and data bits use spaced-one-hot encoding: a mark
//                {A,B,C} = {b,0,~b} followed by a space 000.
//                Every line state is held for UI_CYCLES clock cycles.
//
//  Ports       : CLK, RST           clock, synchronous active-high reset
//                TxRequestEsc       request / hold escape mode
//                TxLpdtEsc          LPDT request (sampled on request rise)
//                TxUlpsEsc          ULPS request (sampled on request rise)
//                TxTriggerEsc[3:0]  trigger request, bit 0 = reset trigger
//                TxDataEsc[7:0]     LPDT payload byte
//                TxValidEsc         payload valid
//                TxReadyEsc         payload accepted this cycle (pulse)
//                LpA, LpB, LpC      LP line state
//                TxStopState        lines are in STOP (111)
//                ErrTxEsc           invalid/ambiguous request (pulse)
//                TxByteCnt[15:0]    completed LPDT bytes in the session
//                                   (only with ESC_TX_BYTE_CNT_EN)
//
//  Options     : `define ESC_TX_BYTE_CNT_EN adds the TxByteCnt output.
//
//  Revision    : 1.0  initial release
// ============================================================================
module esc_mode_tx #(
    parameter int          UI_CYCLES    = 4,
    parameter logic [7:0]  CMD_LPDT     = 8'b11100001,
    parameter logic [7:0]  CMD_ULPS     = 8'b00011110,
    parameter logic [7:0]  CMD_RST_TRIG = 8'b01100010
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TxRequestEsc,
    input  logic        TxLpdtEsc,
    input  logic        TxUlpsEsc,
    input  logic [3:0]  TxTriggerEsc,
    input  logic [7:0]  TxDataEsc,
    input  logic        TxValidEsc,
    output logic        TxReadyEsc,
    output logic        LpA,
    output logic        LpB,
    output logic        LpC,
    output logic        TxStopState,
    output logic        ErrTxEsc
`ifdef ESC_TX_BYTE_CNT_EN
    ,
    output logic [15:0] TxByteCnt
`endif
);

    localparam int                   c_CYC_W   = $clog2(UI_CYCLES + 1);
    localparam logic [c_CYC_W-1:0]   c_UI_LAST = c_CYC_W'(UI_CYCLES - 1);
    localparam logic [c_CYC_W-1:0]   c_CYC_ONE = c_CYC_W'(1);
    localparam logic [c_CYC_W-1:0]   c_CYC_ZERO = '0;

    typedef enum logic [2:0] {
        ST_STOP      = 3'd0,
        ST_ENTRY     = 3'd1,
        ST_CMD       = 3'd2,
        ST_LPDT_IDLE = 3'd3,
        ST_DATA      = 3'd4,
        ST_ULPS_HOLD = 3'd5,
        ST_EXIT      = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [c_CYC_W-1:0]   r_cycCnt;     // cycles spent in current line state
    logic [2:0]           r_bitCnt;     // bit index (also ENTRY step index)
    logic                 r_mark;       // 1: mark half of a bit, 0: space half
    logic [7:0]           r_cmd;
    logic [7:0]           r_data;
    logic                 r_reqDly;
    logic                 r_exitPend;   // request dropped during current byte
    logic                 r_err;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    state_t               w_nextState;
    logic [c_CYC_W-1:0]   w_nextCyc;
    logic [2:0]           w_nextBit;
    logic                 w_nextMark;
    logic                 w_nextExitPend;
    logic                 w_loadCmd;
    logic                 w_loadData;
    logic                 w_ready;
    logic                 w_err;

    logic                 w_uiDone;
    logic                 w_reqRise;
    logic [2:0]           w_reqSel;
    logic                 w_reqOk;
    logic [7:0]           w_cmdSel;
    logic                 w_cmdBit;
    logic                 w_dataBit;
    logic [2:0]           w_lines;

    assign w_uiDone  = (r_cycCnt == c_UI_LAST);
    assign w_reqRise = TxRequestEsc & ~r_reqDly;
    assign w_reqSel  = {TxLpdtEsc, TxUlpsEsc, TxTriggerEsc[0]};
    assign w_reqOk   = ((w_reqSel == 3'b100) || (w_reqSel == 3'b010) ||
                        (w_reqSel == 3'b001)) && (TxTriggerEsc[3:1] == 3'b000);

    always_comb begin
        w_cmdSel = CMD_RST_TRIG;
        if (TxLpdtEsc) begin
            w_cmdSel = CMD_LPDT;
        end else if (TxUlpsEsc) begin
            w_cmdSel = CMD_ULPS;
        end
    end

    // Command goes out MSB first, payload LSB first.
    assign w_cmdBit  = r_cmd[3'd7 - r_bitCnt];
    assign w_dataBit = r_data[r_bitCnt];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_STOP;
            r_cycCnt   <= '0;
            r_bitCnt   <= 3'd0;
            r_mark     <= 1'b1;
            r_cmd      <= 8'h00;
            r_data     <= 8'h00;
            r_reqDly   <= 1'b0;
            r_exitPend <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_cycCnt   <= w_nextCyc;
            r_bitCnt   <= w_nextBit;
            r_mark     <= w_nextMark;
            r_reqDly   <= TxRequestEsc;
            r_exitPend <= w_nextExitPend;
            r_err      <= w_err;
            if (w_loadCmd) begin
                r_cmd <= w_cmdSel;
            end
            if (w_loadData) begin
                r_data <= TxDataEsc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState    = r_state;
        w_nextCyc      = r_cycCnt;
        w_nextBit      = r_bitCnt;
        w_nextMark     = r_mark;
        w_nextExitPend = r_exitPend;
        w_loadCmd      = 1'b0;
        w_loadData     = 1'b0;
        w_ready        = 1'b0;
        w_err          = 1'b0;

        case (r_state)
            ST_STOP: begin
                w_nextCyc      = c_CYC_ZERO;
                w_nextBit      = 3'd0;
                w_nextMark     = 1'b1;
                w_nextExitPend = 1'b0;
                if (w_reqRise) begin
                    if (w_reqOk) begin
                        w_nextState = ST_ENTRY;
                        w_loadCmd   = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end

            ST_ENTRY: begin
                if (!w_uiDone) begin
                    w_nextCyc = r_cycCnt + c_CYC_ONE;
                end else begin
                    w_nextCyc = c_CYC_ZERO;
                    if (r_bitCnt == 3'd3) begin
                        w_nextState = ST_CMD;
                        w_nextBit   = 3'd0;
                        w_nextMark  = 1'b1;
                    end else begin
                        w_nextBit = r_bitCnt + 3'd1;
                    end
                end
            end

            ST_CMD: begin
                if (!w_uiDone) begin
                    w_nextCyc = r_cycCnt + c_CYC_ONE;
                end else begin
                    w_nextCyc = c_CYC_ZERO;
                    if (r_mark) begin
                        w_nextMark = 1'b0;
                    end else begin
                        w_nextMark = 1'b1;
                        w_nextBit  = r_bitCnt + 3'd1;   // wraps 7 -> 0
                        if (r_bitCnt == 3'd7) begin
                            if (r_cmd == CMD_LPDT) begin
                                w_nextState = ST_LPDT_IDLE;
                            end else if (r_cmd == CMD_ULPS) begin
                                w_nextState = ST_ULPS_HOLD;
                            end else begin
                                w_nextState = ST_EXIT;
                            end
                        end
                    end
                end
            end

            ST_LPDT_IDLE: begin
                // Held at least one UI; afterwards the counter saturates and
                // the request/valid decision is taken every cycle.
                if (!w_uiDone) begin
                    w_nextCyc = r_cycCnt + c_CYC_ONE;
                end else if (!TxRequestEsc) begin
                    w_nextState = ST_EXIT;
                    w_nextCyc   = c_CYC_ZERO;
                end else if (TxValidEsc) begin
                    w_ready        = 1'b1;
                    w_loadData     = 1'b1;
                    w_nextState    = ST_DATA;
                    w_nextCyc      = c_CYC_ZERO;
                    w_nextBit      = 3'd0;
                    w_nextMark     = 1'b1;
                    w_nextExitPend = 1'b0;
                end
            end

            ST_DATA: begin
                // A dropped request is remembered so the byte still completes.
                if (!TxRequestEsc) begin
                    w_nextExitPend = 1'b1;
                end
                if (!w_uiDone) begin
                    w_nextCyc = r_cycCnt + c_CYC_ONE;
                end else begin
                    w_nextCyc = c_CYC_ZERO;
                    if (r_mark) begin
                        w_nextMark = 1'b0;
                    end else begin
                        w_nextMark = 1'b1;
                        w_nextBit  = r_bitCnt + 3'd1;   // wraps 7 -> 0
                        if (r_bitCnt == 3'd7) begin
                            if (!TxRequestEsc || r_exitPend) begin
                                w_nextState = ST_EXIT;
                            end else if (TxValidEsc) begin
                                // Back-to-back byte: no extra space inserted.
                                w_ready    = 1'b1;
                                w_loadData = 1'b1;
                            end else begin
                                w_nextState = ST_LPDT_IDLE;
                            end
                        end
                    end
                end
            end

            ST_ULPS_HOLD: begin
                if (!w_uiDone) begin
                    w_nextCyc = r_cycCnt + c_CYC_ONE;
                end else if (!TxRequestEsc) begin
                    w_nextState = ST_EXIT;
                    w_nextCyc   = c_CYC_ZERO;
                end
            end

            ST_EXIT: begin
                if (!w_uiDone) begin
                    w_nextCyc = r_cycCnt + c_CYC_ONE;
                end else begin
                    w_nextState = ST_STOP;
                    w_nextCyc   = c_CYC_ZERO;
                end
            end

            default: begin
                w_nextState = ST_STOP;
                w_nextCyc   = c_CYC_ZERO;
                w_nextBit   = 3'd0;
                w_nextMark  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line state decode
    // ------------------------------------------------------------------
    always_comb begin
        w_lines = 3'b000;
        case (r_state)
            ST_STOP: w_lines = 3'b111;
            ST_ENTRY: begin
                case (r_bitCnt[1:0])
                    2'd0:    w_lines = 3'b100;
                    2'd2:    w_lines = 3'b001;
                    default: w_lines = 3'b000;
                endcase
            end
            ST_CMD: begin
                if (r_mark) begin
                    w_lines = {w_cmdBit, 1'b0, ~w_cmdBit};
                end
            end
            ST_DATA: begin
                if (r_mark) begin
                    w_lines = {w_dataBit, 1'b0, ~w_dataBit};
                end
            end
            ST_EXIT: w_lines = 3'b100;
            default: w_lines = 3'b000;
        endcase
    end

    assign {LpA, LpB, LpC} = w_lines;
    assign TxStopState     = (r_state == ST_STOP);
    // Acceptance is combinational so TxDataEsc is taken in the pulse cycle;
    // masked while RST is high so no byte is acknowledged during reset.
    assign TxReadyEsc      = w_ready & ~RST;
    assign ErrTxEsc        = r_err;

`ifdef ESC_TX_BYTE_CNT_EN
    logic [15:0] r_byteCnt;
    logic        w_sessEnter;
    logic        w_byteDone;

    assign w_sessEnter = (r_state == ST_STOP) && (w_nextState == ST_ENTRY);
    assign w_byteDone  = (r_state == ST_DATA) && w_uiDone && !r_mark &&
                         (r_bitCnt == 3'd7);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_byteCnt <= 16'h0000;
        end else if (w_sessEnter) begin
            r_byteCnt <= 16'h0000;
        end else if (w_byteDone && (r_byteCnt != 16'hFFFF)) begin
            r_byteCnt <= r_byteCnt + 16'd1;
        end
    end

    assign TxByteCnt = r_byteCnt;
`endif

endmodule
`default_nettype wire

// File: doc/esc_mode_tx.md
Name: esc_mode_tx

Overview:
- Master-side C-PHY low-power escape-mode transmitter. It drives the LP line states on A/B/C that the slave escape decoder and LP clock recovery consume.
- Generates the escape entry sequence, the 8-bit command (LPDT, ULPS or Reset-Trigger), LPDT payload bytes, and the exit-to-stop sequence.
- Every bit uses spaced-one-hot encoding: a mark state followed by a space state.

Parameters:
- UI_CYCLES, 4, CLK cycles each LP line state is held (minimum 1).
- CMD_LPDT, 8'b11100001, low-power data command code.
- CMD_ULPS, 8'b00011110, ultra-low-power command code.
- CMD_RST_TRIG, 8'b01100010, reset-trigger command code.

Ports:
- CLK  in  1  block clock; all logic on its rising edge.
- RST  in  1  synchronous reset, active-high.
- TxRequestEsc  in  1  hold high to request and stay in escape mode.
- TxLpdtEsc  in  1  request LPDT; sampled with TxRequestEsc rise.
- TxUlpsEsc  in  1  request ULPS; sampled with TxRequestEsc rise.
- TxTriggerEsc  in  4  trigger request; only bit 0 (reset trigger) is supported.
- TxDataEsc  in  8  LPDT payload byte.
- TxValidEsc  in  1  TxDataEsc valid.
- TxReadyEsc  out  1  one-cycle pulse: the byte on TxDataEsc is accepted.
- LpA, LpB, LpC  out  1 each  LP line state driven to the lane.
- TxStopState  out  1  high while in STOP (lines 111).
- ErrTxEsc  out  1  one-cycle pulse on an invalid or ambiguous request.

Behaviour:
- Reset: state=STOP, {LpA,LpB,LpC}=111, TxStopState=1, TxReadyEsc=0, ErrTxEsc=0, all counters 0. Reset applied mid-operation aborts immediately; lines show 111 on the cycle after RST is sampled.
- Every line state below is held exactly UI_CYCLES cycles. A cycle counter reloads on every state change.
- STOP:
  - Act on the rising edge of TxRequestEsc.
  - Exactly one of {TxLpdtEsc, TxUlpsEsc, TxTriggerEsc[0]} high, and TxTriggerEsc[3:1]=0: latch the command code and go to ENTRY; lines change on the next cycle.
  - Otherwise pulse ErrTxEsc and remain in STOP.
- ENTRY: line sequence 100, 000, 001, 000, then CMD.
- CMD:
  - Send the command MSB first.
  - Each bit is a mark {A,B,C}={b,0,~b} followed by a space 000.
  - 16 line states total.
  - Then go to LPDT_IDLE (LPDT), ULPS_HOLD (ULPS) or EXIT (trigger).
- LPDT_IDLE: lines 000.
  - TxRequestEsc low: go to EXIT.
  - Else TxValidEsc high: pulse TxReadyEsc for one cycle, latch TxDataEsc, go to DATA.
  - A request drop takes priority over simultaneous valid data.
- DATA:
  - Send the byte LSB first, same mark/space encoding as CMD (16 line states).
  - The byte is never truncated: a TxRequestEsc drop mid-byte finishes the byte, then goes to EXIT.
  - Back-to-back: valid high at the end of the byte's last space state goes straight to the next byte with no extra space.
- ULPS_HOLD: lines 000 until TxRequestEsc is low, then EXIT.
- EXIT: 100 for UI_CYCLES, then STOP (111, TxStopState=1).
- TxStopState is low in every state except STOP.
- TxReadyEsc is never high outside LPDT_IDLE/DATA boundaries.
- Lines never show 111 except in STOP. An A/B/C mark and C=~A are never both 0 during a mark.
- Counters:
  - Cycle counter width is clog2(UI_CYCLES+1).
  - Bit counter is 3 bits and wraps 7 to 0 at the end of a byte or command.

Optional Feature:
- Macro ESC_TX_BYTE_CNT_EN.
- When defined:
  - Adds output TxByteCnt[15:0], which counts completed LPDT bytes in the current escape session.
  - Cleared on RST and on entry to ENTRY.
  - Saturates at 16'hFFFF.
  - Held after EXIT until the next entry.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (UI_CYCLES=2):
- LPDT with byte 8'hA5:
  - Lines: entry 100,000,001,000; then 16 CMD states for 11100001; then data marks LSB first 1,0,1,0,0,1,0,1, each followed by 000; then 100, 111.
  - TxReadyEsc pulses once. Total length from request to STOP = (4+16+1+16+1)×2 cycles plus LPDT_IDLE wait cycles.
- ULPS: command marks 0,0,0,1,1,1,1,0 (A pattern), lines held 000 for 20 cycles after the command. On TxRequestEsc drop: 100 for 2 cycles, then 111 with TxStopState=1.
- Reset trigger: command 01100010, then EXIT directly with no idle state. TxReadyEsc is never asserted.
- Invalid request, TxLpdtEsc=1 and TxUlpsEsc=1 together: ErrTxEsc pulses exactly one cycle, lines stay 111, no entry.
- Two back-to-back bytes 8'h01, 8'h80 with TxRequestEsc dropped during the second byte:
  - Both bytes are sent in full with no extra space between them; then EXIT.
  - With ESC_TX_BYTE_CNT_EN defined, TxByteCnt=2.
- RST asserted during the third data bit: lines are 111 on the next cycle, and all outputs are at reset values.
